// File: rtl/spi_target.sv
// SPI target (responder): oversamples SCLK/SS/MOSI in the io_clock domain,
// deserialises MOSI into words, and serialises queued TX words onto MISO,
// MSB first, in the SPI mode selected by CPOL/CPHA.
module spi_target #(
    parameter int                    DATA_WIDTH = 8,
    parameter bit                    CPOL       = 1'b0,
    parameter bit                    CPHA       = 1'b0,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = '1
) (
    input  logic                  io_clock,
    input  logic                  io_resetn,
    input  logic                  io_spi_sclk,
    input  logic                  io_spi_ss,
    input  logic                  io_spi_mosi,
    output logic                  io_spi_miso,
    output logic                  io_spi_miso_oe,
    input  logic                  io_tx_valid,
    output logic                  io_tx_ready,
    input  logic [DATA_WIDTH-1:0] io_tx_payload,
    output logic                  io_rx_valid,
    output logic [DATA_WIDTH-1:0] io_rx_payload,
    output logic                  io_tx_underrun,
    output logic                  io_busy
);

    localparam int               CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    // Synchroniser chains; sclk has a third stage used only for edge detection
    logic sclk_meta;
    logic sclk_sync;
    logic sclk_prev;
    logic ss_meta;
    logic ss_sync;
    logic mosi_meta;
    logic mosi_sync;

    // Edge classification derived from the synchronised clock
    logic leading_edge;
    logic trailing_edge;
    logic sample_edge;
    logic drive_edge;

    // FSM state and per-cycle actions
    state_t state;
    state_t state_next;
    logic   enter_frame;
    logic   leave_frame;
    logic   do_sample;
    logic   do_drive;

    // Datapath
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_word;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_full;
    logic                  word_done;
    logic                  load_tx;
    logic                  accept_tx;

    // Two-flop synchronisers for the asynchronous SPI pins; reset to idle bus levels
    always_ff @(posedge io_clock or negedge io_resetn) begin
        if (!io_resetn) begin
            sclk_meta <= CPOL;
            sclk_sync <= CPOL;
            sclk_prev <= CPOL;
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sclk_meta <= io_spi_sclk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            ss_meta   <= io_spi_ss;
            ss_sync   <= ss_meta;
            mosi_meta <= io_spi_mosi;
            mosi_sync <= mosi_meta;
        end
    end

    // Leading edge leaves the idle level, trailing edge returns to it;
    // CPHA picks which one samples MOSI and which one advances MISO
    always_comb begin
        leading_edge  = (sclk_prev == CPOL) && (sclk_sync != CPOL);
        trailing_edge = (sclk_prev != CPOL) && (sclk_sync == CPOL);
        sample_edge   = CPHA ? trailing_edge : leading_edge;
        drive_edge    = CPHA ? leading_edge : trailing_edge;
    end

    // Frame state register
    always_ff @(posedge io_clock or negedge io_resetn) begin
        if (!io_resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame FSM: the state trails ss_sync by one cycle, so a mismatch marks
    // the frame entry/exit cycle; SCLK edges only count inside a frame
    always_comb begin
        state_next  = state;
        enter_frame = 1'b0;
        leave_frame = 1'b0;
        do_sample   = 1'b0;
        do_drive    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!ss_sync) begin
                    state_next  = ST_ACTIVE;
                    enter_frame = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ss_sync) begin
                    state_next  = ST_IDLE;
                    leave_frame = 1'b1;
                end else begin
                    do_sample = sample_edge;
                    do_drive  = drive_edge;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Word boundary, TX reload and TX handshake decisions
    always_comb begin
        rx_word   = {rx_shift[DATA_WIDTH-2:0], mosi_sync};
        word_done = do_sample && (bit_cnt == LAST_BIT);
        load_tx   = enter_frame || word_done;
        accept_tx = io_tx_valid && !hold_full;
    end

    // Bit counter restarts on every frame boundary and wraps at each word end
    always_ff @(posedge io_clock or negedge io_resetn) begin
        if (!io_resetn) begin
            bit_cnt <= '0;
        end else if (enter_frame || leave_frame) begin
            bit_cnt <= '0;
        end else if (do_sample) begin
            if (word_done) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // RX shift register; a partial word is thrown away when the frame ends
    always_ff @(posedge io_clock or negedge io_resetn) begin
        if (!io_resetn) begin
            rx_shift <= '0;
        end else if (enter_frame || leave_frame) begin
            rx_shift <= '0;
        end else if (do_sample) begin
            rx_shift <= rx_word;
        end
    end

    // Completed RX word is published with a single-cycle valid pulse and held
    always_ff @(posedge io_clock or negedge io_resetn) begin
        if (!io_resetn) begin
            io_rx_valid   <= 1'b0;
            io_rx_payload <= '0;
        end else begin
            io_rx_valid <= word_done;
            if (word_done) begin
                io_rx_payload <= rx_word;
            end
        end
    end

    // TX shift register: reload from the holding register (or the idle word)
    // at frame start and word end; the first drive edge of each word does not
    // shift so the fresh MSB stays on MISO for a full bit time
    always_ff @(posedge io_clock or negedge io_resetn) begin
        if (!io_resetn) begin
            tx_shift <= '0;
        end else if (leave_frame) begin
            tx_shift <= '0;
        end else if (load_tx) begin
            tx_shift <= hold_full ? hold_data : IDLE_WORD;
        end else if (do_drive && (bit_cnt != '0)) begin
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // Underrun pulse whenever a reload finds the holding register empty
    always_ff @(posedge io_clock or negedge io_resetn) begin
        if (!io_resetn) begin
            io_tx_underrun <= 1'b0;
        end else begin
            io_tx_underrun <= load_tx && !hold_full;
        end
    end

    // Single-entry TX holding register; an accept can only happen while empty,
    // so a same-cycle reload has already taken the idle word
    always_ff @(posedge io_clock or negedge io_resetn) begin
        if (!io_resetn) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (accept_tx) begin
            hold_data <= io_tx_payload;
            hold_full <= 1'b1;
        end else if (load_tx && hold_full) begin
            hold_full <= 1'b0;
        end
    end

    // Output pins follow the TX MSB and the synchronised select
    always_comb begin
        io_spi_miso    = tx_shift[DATA_WIDTH-1];
        io_spi_miso_oe = ~ss_sync;
        io_busy        = ~ss_sync;
        io_tx_ready    = ~hold_full;
    end

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: three instances cover mode 0, CPOL=1/CPHA=1
// and CPOL=0/CPHA=1, driven by a bit-banged SPI controller model.
module tb_spi_target;

    localparam int       W      = 8;
    localparam int       H      = 8;
    localparam bit [2:0] CPOL_V = 3'b010;
    localparam bit [2:0] CPHA_V = 3'b110;

    logic       io_clock;
    logic       io_resetn;
    logic [2:0] sclk_v;
    logic [2:0] ss_v;
    logic       mosi;
    logic [2:0] tx_valid_v;
    logic [W-1:0] tx_payload;

    logic [2:0] miso_v;
    logic [2:0] oe_v;
    logic [2:0] ready_v;
    logic [2:0] rx_valid_v;
    logic [2:0] underrun_v;
    logic [2:0] busy_v;
    logic [W-1:0] rx_payload_v [3];

    int rx_cnt [3];
    logic [W-1:0] rx_last [3];
    int ur_cnt [3];

    int n_cmp;
    int n_fail;

    typedef struct {
        int           inst;
        bit           queue;
        logic [W-1:0] tx_word;
        logic [W-1:0] mosi_word;
        logic [W-1:0] exp_rx;
        logic [W-1:0] exp_miso;
        int           exp_entry_ur;
        int           exp_total_ur;
    } vec_t;

    vec_t vecs [6];

    spi_target #(.DATA_WIDTH(W), .CPOL(1'b0), .CPHA(1'b0)) dut_m0 (
        .io_clock(io_clock), .io_resetn(io_resetn),
        .io_spi_sclk(sclk_v[0]), .io_spi_ss(ss_v[0]), .io_spi_mosi(mosi),
        .io_spi_miso(miso_v[0]), .io_spi_miso_oe(oe_v[0]),
        .io_tx_valid(tx_valid_v[0]), .io_tx_ready(ready_v[0]), .io_tx_payload(tx_payload),
        .io_rx_valid(rx_valid_v[0]), .io_rx_payload(rx_payload_v[0]),
        .io_tx_underrun(underrun_v[0]), .io_busy(busy_v[0])
    );

    spi_target #(.DATA_WIDTH(W), .CPOL(1'b1), .CPHA(1'b1)) dut_m3 (
        .io_clock(io_clock), .io_resetn(io_resetn),
        .io_spi_sclk(sclk_v[1]), .io_spi_ss(ss_v[1]), .io_spi_mosi(mosi),
        .io_spi_miso(miso_v[1]), .io_spi_miso_oe(oe_v[1]),
        .io_tx_valid(tx_valid_v[1]), .io_tx_ready(ready_v[1]), .io_tx_payload(tx_payload),
        .io_rx_valid(rx_valid_v[1]), .io_rx_payload(rx_payload_v[1]),
        .io_tx_underrun(underrun_v[1]), .io_busy(busy_v[1])
    );

    spi_target #(.DATA_WIDTH(W), .CPOL(1'b0), .CPHA(1'b1)) dut_m1 (
        .io_clock(io_clock), .io_resetn(io_resetn),
        .io_spi_sclk(sclk_v[2]), .io_spi_ss(ss_v[2]), .io_spi_mosi(mosi),
        .io_spi_miso(miso_v[2]), .io_spi_miso_oe(oe_v[2]),
        .io_tx_valid(tx_valid_v[2]), .io_tx_ready(ready_v[2]), .io_tx_payload(tx_payload),
        .io_rx_valid(rx_valid_v[2]), .io_rx_payload(rx_payload_v[2]),
        .io_tx_underrun(underrun_v[2]), .io_busy(busy_v[2])
    );

    // 10 ns system clock
    initial begin
        io_clock = 1'b0;
        forever #5 io_clock = ~io_clock;
    end

    // Event monitor: counts RX completions and underrun pulses per instance
    initial begin
        for (int i = 0; i < 3; i++) begin
            rx_cnt[i]  = 0;
            rx_last[i] = '0;
            ur_cnt[i]  = 0;
        end
    end

    always @(negedge io_clock) begin
        for (int i = 0; i < 3; i++) begin
            if (rx_valid_v[i] === 1'b1) begin
                rx_cnt[i]  <= rx_cnt[i] + 1;
                rx_last[i] <= rx_payload_v[i];
            end
            if (underrun_v[i] === 1'b1) begin
                ur_cnt[i] <= ur_cnt[i] + 1;
            end
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge io_clock);
    endtask

    // Offer one TX word and wait (bounded) for it to be accepted
    task automatic queue_word(input int inst, input logic [W-1:0] w);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge io_clock);
            if (ready_v[inst] === 1'b1) begin
                tx_payload       = w;
                tx_valid_v[inst] = 1'b1;
                @(negedge io_clock);
                tx_valid_v[inst] = 1'b0;
                done = 1'b1;
            end
        end
        checkOutput("queue_accept", {31'b0, done}, 32'd1);
    endtask

    task automatic start_frame(input int inst);
        @(negedge io_clock);
        ss_v[inst] = 1'b0;
        wait_cyc(H);
    endtask

    task automatic end_frame(input int inst);
        wait_cyc(H);
        ss_v[inst] = 1'b1;
        wait_cyc(6);
    endtask

    // Controller model: shifts nbits of mo out on MOSI, collects MISO into mi
    task automatic xfer(input int inst, input logic [W-1:0] mo, input int nbits,
                        output logic [W-1:0] mi);
        logic [W-1:0] word;
        word = mo;
        mi   = '0;
        for (int b = 0; b < nbits; b++) begin
            if (!CPHA_V[inst]) begin
                mosi = word[W-1-b];
                wait_cyc(H);
                mi = {mi[W-2:0], miso_v[inst]};
                sclk_v[inst] = ~CPOL_V[inst];
                wait_cyc(H);
                sclk_v[inst] = CPOL_V[inst];
            end else begin
                sclk_v[inst] = ~CPOL_V[inst];
                mosi = word[W-1-b];
                wait_cyc(H);
                mi = {mi[W-2:0], miso_v[inst]};
                sclk_v[inst] = CPOL_V[inst];
                wait_cyc(H);
            end
        end
    endtask

    // One table row: optional queued word, single-word frame, full checks
    task automatic applyStimulus(input vec_t v, input int idx);
        int           rx0;
        int           ur0;
        logic [W-1:0] mi;
        if (v.queue) begin
            queue_word(v.inst, v.tx_word);
        end
        rx0 = rx_cnt[v.inst];
        ur0 = ur_cnt[v.inst];
        start_frame(v.inst);
        checkOutput($sformatf("v%0d busy_in_frame", idx), {31'b0, busy_v[v.inst]}, 32'd1);
        checkOutput($sformatf("v%0d oe_in_frame", idx), {31'b0, oe_v[v.inst]}, 32'd1);
        checkOutput($sformatf("v%0d entry_underruns", idx), ur_cnt[v.inst] - ur0, v.exp_entry_ur);
        xfer(v.inst, v.mosi_word, W, mi);
        checkOutput($sformatf("v%0d rx_count", idx), rx_cnt[v.inst] - rx0, 32'd1);
        checkOutput($sformatf("v%0d rx_payload", idx), {24'b0, rx_last[v.inst]}, {24'b0, v.exp_rx});
        checkOutput($sformatf("v%0d miso_word", idx), {24'b0, mi}, {24'b0, v.exp_miso});
        end_frame(v.inst);
        checkOutput($sformatf("v%0d total_underruns", idx), ur_cnt[v.inst] - ur0, v.exp_total_ur);
        checkOutput($sformatf("v%0d busy_after", idx), {31'b0, busy_v[v.inst]}, 32'd0);
    endtask

    initial begin
        int           rx0;
        int           ur0;
        logic [W-1:0] mi;
        logic [W-1:0] mi2;

        n_cmp      = 0;
        n_fail     = 0;
        io_resetn  = 1'b0;
        ss_v       = 3'b111;
        sclk_v     = CPOL_V;
        mosi       = 1'b0;
        tx_valid_v = 3'b000;
        tx_payload = '0;

        // inst 0: mode 0, inst 1: CPOL=1/CPHA=1, inst 2: CPOL=0/CPHA=1.
        // Every reload with an empty holding register underruns, including
        // the reload at the end of the last word of a frame.
        vecs[0] = '{0, 1'b1, 8'h3C, 8'hA5, 8'hA5, 8'h3C, 0, 1};
        vecs[1] = '{0, 1'b0, 8'h00, 8'h12, 8'h12, 8'hFF, 1, 2};
        vecs[2] = '{1, 1'b1, 8'h69, 8'h96, 8'h96, 8'h69, 0, 1};
        vecs[3] = '{2, 1'b1, 8'h69, 8'h96, 8'h96, 8'h69, 0, 1};
        vecs[4] = '{2, 1'b0, 8'h00, 8'h5A, 8'h5A, 8'hFF, 1, 2};
        vecs[5] = '{1, 1'b1, 8'hC3, 8'h0F, 8'h0F, 8'hC3, 0, 1};

        wait_cyc(5);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset%0d miso", i), {31'b0, miso_v[i]}, 32'd0);
            checkOutput($sformatf("reset%0d oe", i), {31'b0, oe_v[i]}, 32'd0);
            checkOutput($sformatf("reset%0d rx_valid", i), {31'b0, rx_valid_v[i]}, 32'd0);
            checkOutput($sformatf("reset%0d rx_payload", i), {24'b0, rx_payload_v[i]}, 32'd0);
            checkOutput($sformatf("reset%0d underrun", i), {31'b0, underrun_v[i]}, 32'd0);
            checkOutput($sformatf("reset%0d busy", i), {31'b0, busy_v[i]}, 32'd0);
            checkOutput($sformatf("reset%0d tx_ready", i), {31'b0, ready_v[i]}, 32'd1);
        end
        io_resetn = 1'b1;
        wait_cyc(5);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Back-to-back: 0x11 queued, 0x22 accepted while the first word runs
        $display("[TB] back-to-back frame");
        queue_word(0, 8'h11);
        ur0 = ur_cnt[0];
        start_frame(0);
        checkOutput("b2b tx_ready_after_entry", {31'b0, ready_v[0]}, 32'd1);
        fork
            begin
                rx0 = rx_cnt[0];
                xfer(0, 8'hC3, W, mi);
                checkOutput("b2b rx_count1", rx_cnt[0] - rx0, 32'd1);
                checkOutput("b2b rx1", {24'b0, rx_last[0]}, 32'hC3);
                checkOutput("b2b miso1", {24'b0, mi}, 32'h11);
                xfer(0, 8'h5A, W, mi2);
                checkOutput("b2b rx_count2", rx_cnt[0] - rx0, 32'd2);
                checkOutput("b2b rx2", {24'b0, rx_last[0]}, 32'h5A);
                checkOutput("b2b miso2", {24'b0, mi2}, 32'h22);
            end
            begin
                wait_cyc(30);
                tx_payload    = 8'h22;
                tx_valid_v[0] = 1'b1;
                @(negedge io_clock);
                tx_valid_v[0] = 1'b0;
                @(negedge io_clock);
                checkOutput("b2b tx_ready_after_accept", {31'b0, ready_v[0]}, 32'd0);
                wait_cyc(80);
                checkOutput("b2b tx_ready_before_load", {31'b0, ready_v[0]}, 32'd0);
                wait_cyc(30);
                checkOutput("b2b tx_ready_after_load", {31'b0, ready_v[0]}, 32'd1);
            end
        join
        end_frame(0);
        checkOutput("b2b total_underruns", ur_cnt[0] - ur0, 32'd1);

        // Abort: SS rises after five bits, partial word must vanish
        $display("[TB] abort frame");
        rx0 = rx_cnt[0];
        start_frame(0);
        xfer(0, 8'hFF, 5, mi);
        end_frame(0);
        checkOutput("abort busy", {31'b0, busy_v[0]}, 32'd0);
        checkOutput("abort rx_count", rx_cnt[0] - rx0, 32'd0);
        start_frame(0);
        xfer(0, 8'h81, W, mi);
        end_frame(0);
        checkOutput("abort next rx_count", rx_cnt[0] - rx0, 32'd1);
        checkOutput("abort next rx", {24'b0, rx_last[0]}, 32'h81);

        // Reset in the middle of a word with a word waiting in the holding register
        $display("[TB] reset mid-word");
        start_frame(0);
        queue_word(0, 8'h5A);
        checkOutput("rst tx_ready_full", {31'b0, ready_v[0]}, 32'd0);
        xfer(0, 8'hFF, 3, mi);
        io_resetn = 1'b0;
        @(negedge io_clock);
        checkOutput("rst miso", {31'b0, miso_v[0]}, 32'd0);
        checkOutput("rst oe", {31'b0, oe_v[0]}, 32'd0);
        checkOutput("rst rx_valid", {31'b0, rx_valid_v[0]}, 32'd0);
        checkOutput("rst rx_payload", {24'b0, rx_payload_v[0]}, 32'd0);
        checkOutput("rst underrun", {31'b0, underrun_v[0]}, 32'd0);
        checkOutput("rst busy", {31'b0, busy_v[0]}, 32'd0);
        checkOutput("rst tx_ready", {31'b0, ready_v[0]}, 32'd1);
        ss_v[0]   = 1'b1;
        sclk_v[0] = CPOL_V[0];
        wait_cyc(4);
        io_resetn = 1'b1;
        wait_cyc(4);
        rx0 = rx_cnt[0];
        start_frame(0);
        xfer(0, 8'hE7, W, mi);
        end_frame(0);
        checkOutput("rst next rx_count", rx_cnt[0] - rx0, 32'd1);
        checkOutput("rst next rx", {24'b0, rx_last[0]}, 32'hE7);
        checkOutput("rst next miso", {24'b0, mi}, 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
